// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - run/halt/single-step/burst controller issuing cpu_en pulses per div_clk rise
module cpu_step_ctrl #(
  parameter int CNT_W = 8,
  parameter int RET_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_clk,
  input  logic             run_btn,
  input  logic             halt_btn,
  input  logic             step_btn,
  input  logic             burst_btn,
  input  logic [CNT_W-1:0] step_count,
  output logic             cpu_en,
  output logic [1:0]       mode,
  output logic             busy,
  output logic [CNT_W-1:0] remaining,
  output logic [RET_W-1:0] retired
);

  localparam logic [1:0] HALT  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] STEP  = 2'b10;
  localparam logic [1:0] BURST = 2'b11;

  // Button bit order: {burst, step, halt, run}
  logic [3:0] btn_s1, btn_s2, btn_prev, req;
  logic       req_run, req_halt, req_step, req_burst;
  logic       div_q, tick, allowed;
  logic [1:0] mode_nxt;
  logic [CNT_W-1:0] rem_nxt;

  assign req       = btn_s2 & ~btn_prev;
  assign req_run   = req[0];
  assign req_halt  = req[1];
  assign req_step  = req[2];
  assign req_burst = req[3];
  assign tick      = div_clk & ~div_q;

  always_comb begin
    mode_nxt = mode;
    rem_nxt  = remaining;
    allowed  = 1'b0;
    case (mode)
      HALT: begin
        if (req_halt) begin
          mode_nxt = HALT;
        end else if (req_run) begin
          mode_nxt = RUN;
        end else if (req_burst) begin
          // A zero-length burst is a no-op rather than an endless burst
          if (step_count != '0) begin
            mode_nxt = BURST;
            rem_nxt  = step_count;
          end
        end else if (req_step) begin
          mode_nxt = STEP;
        end
      end
      RUN: begin
        allowed = ~req_halt;
        if (req_halt) mode_nxt = HALT;
      end
      STEP: begin
        allowed = ~req_halt;
        if (req_halt || tick) mode_nxt = HALT;
      end
      BURST: begin
        allowed = ~req_halt;
        if (req_halt) begin
          mode_nxt = HALT;
          rem_nxt  = '0;
        end else if (tick) begin
          rem_nxt = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) mode_nxt = HALT;
        end
      end
      default: mode_nxt = HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1    <= '0;
      btn_s2    <= '0;
      btn_prev  <= '0;
      // div_q starts high so a div_clk already high at release is not a tick
      div_q     <= 1'b1;
      cpu_en    <= 1'b0;
      mode      <= HALT;
      busy      <= 1'b0;
      remaining <= '0;
      retired   <= '0;
    end else begin
      btn_s1    <= {burst_btn, step_btn, halt_btn, run_btn};
      btn_s2    <= btn_s1;
      btn_prev  <= btn_s2;
      div_q     <= div_clk;
      cpu_en    <= tick & allowed;
      mode      <= mode_nxt;
      busy      <= (mode_nxt != HALT);
      remaining <= rem_nxt;
      if (cpu_en) retired <= retired + RET_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb/tb_cpu_step_ctrl.sv - scoreboard bench for cpu_step_ctrl (RET_W=4 build)
module tb_cpu_step_ctrl;

  logic       clk = 1'b0;
  logic       reset, div_clk, run_btn, halt_btn, step_btn, burst_btn;
  logic [7:0] step_count;
  logic       cpu_en, busy;
  logic [1:0] mode;
  logic [7:0] remaining;
  logic [3:0] retired;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0] ret;
    logic [7:0] rem;
    logic [1:0] md;
    logic       bsy;
  } exp_t;

  exp_t q[$];
  exp_t got_e;

  cpu_step_ctrl #(.CNT_W(8), .RET_W(4)) dut (
    .clk(clk), .reset(reset), .div_clk(div_clk),
    .run_btn(run_btn), .halt_btn(halt_btn), .step_btn(step_btn), .burst_btn(burst_btn),
    .step_count(step_count), .cpu_en(cpu_en), .mode(mode), .busy(busy),
    .remaining(remaining), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cpu_en pulse consumes one expected record
  always @(negedge clk) begin
    if (!reset && cpu_en) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: got cpu_en=1 expected no pulse at %0t", $time);
      end else begin
        got_e = q.pop_front();
        check("pulse_retired", 32'(retired), 32'(got_e.ret));
        check("pulse_remaining", 32'(remaining), 32'(got_e.rem));
        check("pulse_mode", 32'(mode), 32'(got_e.md));
        check("pulse_busy", 32'(busy), 32'(got_e.bsy));
      end
    end
  end

  task automatic push(input int ret, input int rem, input int md, input int bsy);
    exp_t e;
    e.ret = 4'(ret);
    e.rem = 8'(rem);
    e.md  = 2'(md);
    e.bsy = 1'(bsy);
    q.push_back(e);
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0: run_btn = v;
      1: halt_btn = v;
      2: step_btn = v;
      default: burst_btn = v;
    endcase
  endtask

  // Returns at posedge+1 just after the edge that applies the request
  task automatic press(input int which);
    set_btn(which, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    set_btn(which, 1'b0);
  endtask

  task automatic div_period();
    div_clk = 1'b1;
    repeat (2) @(posedge clk);
    #1 div_clk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; div_clk = 1'b1;
    run_btn = 0; halt_btn = 0; step_btn = 0; burst_btn = 0;
    step_count = 8'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1: release with div_clk high, idle in HALT
    repeat (20) @(posedge clk);
    #1;
    check("t1_mode", 32'(mode), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_retired", 32'(retired), 32'd0);
    check("t1_remaining", 32'(remaining), 32'd0);
    div_clk = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 2: single step
    press(2);
    check("t2_mode_step", 32'(mode), 32'd2);
    check("t2_busy", 32'(busy), 32'd1);
    push(0, 0, 0, 0);
    div_period();
    div_period();
    check("t2_mode_halt", 32'(mode), 32'd0);
    check("t2_retired", 32'(retired), 32'd1);

    // 3: burst of 3
    step_count = 8'd3;
    press(3);
    check("t3_mode_burst", 32'(mode), 32'd3);
    check("t3_remaining", 32'(remaining), 32'd3);
    push(1, 2, 3, 1);
    push(2, 1, 3, 1);
    push(3, 0, 0, 0);
    repeat (4) div_period();
    check("t3_mode_halt", 32'(mode), 32'd0);
    check("t3_remaining_end", 32'(remaining), 32'd0);
    check("t3_retired", 32'(retired), 32'd4);

    // 4: run 10 periods, halt request coincident with the 11th tick
    press(0);
    check("t4_mode_run", 32'(mode), 32'd1);
    for (int i = 0; i < 10; i++) begin
      push(4 + i, 0, 1, 1);
      div_period();
    end
    halt_btn = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 div_clk = 1'b1;
    @(posedge clk);
    #1;
    check("t4_mode_halt", 32'(mode), 32'd0);
    check("t4_no_pulse", 32'(cpu_en), 32'd0);
    halt_btn = 1'b0;
    @(posedge clk);
    #1 div_clk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t4_retired", 32'(retired), 32'd14);

    // 5: zero-length burst is a no-op; step ignored while running
    step_count = 8'd0;
    press(3);
    repeat (2) @(posedge clk);
    #1;
    check("t5_burst0_mode", 32'(mode), 32'd0);
    check("t5_burst0_rem", 32'(remaining), 32'd0);
    press(0);
    press(2);
    check("t5_step_ignored", 32'(mode), 32'd1);

    // 6: retired wraps 15 -> 0
    push(14, 0, 1, 1);
    push(15, 0, 1, 1);
    push(0, 0, 1, 1);
    repeat (3) div_period();
    press(1);
    check("t6_mode_halt", 32'(mode), 32'd0);
    check("t6_retired_wrap", 32'(retired), 32'd1);

    // 6: late step_count change ignored; async reset mid-burst
    step_count = 8'd5;
    press(3);
    check("t6_remaining5", 32'(remaining), 32'd5);
    step_count = 8'd9;
    push(1, 4, 3, 1);
    div_period();
    div_clk = 1'b1;
    @(posedge clk);
    #1;
    check("t6_remaining3", 32'(remaining), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_cpu_en", 32'(cpu_en), 32'd0);
    check("t6_rst_remaining", 32'(remaining), 32'd0);
    check("t6_rst_mode", 32'(mode), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_retired", 32'(retired), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("t6_post_mode", 32'(mode), 32'd0);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
